// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and helper functions shared by the uart_nic slice.
package uart_pkg;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_nic_fifo.sv
// uart_nic_fifo: synchronous RX FIFO with count; the head output holds the
// last popped value while the FIFO is empty.
module uart_nic_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_push,
  input  logic                               i_pop,
  input  logic [DATA_W-1:0]                  i_data,
  output logic [DATA_W-1:0]                  o_head,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
  output logic                               o_full,
  output logic                               o_empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [OCC_W-1:0]  r_count;
  logic [DATA_W-1:0] r_lastHead;
  logic              w_doPush;
  logic              w_doPop;

  assign o_full   = (r_count == OCC_W'(FIFO_DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_count  = r_count;
  assign o_head   = o_empty ? r_lastHead : r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_lastHead <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop) begin
        r_rdPtr    <= r_rdPtr + 1'b1;
        r_lastHead <= r_mem[r_rdPtr];
      end
      if (w_doPush && !w_doPop) r_count <= r_count + 1'b1;
      else if (w_doPop && !w_doPush) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_nic.sv
// uart_nic: UART network-interface controller with TX serialiser, RX deserialiser
// and RX FIFO. Define UART_NIC_PARITY_EN to add an even-parity bit to every frame.
module uart_nic
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_W-1:0]               data_in,
  input  logic                            write_nic,
  output logic                            tx_ready,
  output logic                            tx,
  input  logic                            rx,
  output logic [DATA_W-1:0]               data_out,
  input  logic                            read_nic,
  output logic                            read_nic_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            frame_err,
  output logic                            overrun,
  output logic                            parity_err
);
  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV/2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
`ifdef UART_NIC_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  tx_state_t         r_txState, w_txStateNxt;
  logic [CNT_W-1:0]  r_txCnt, w_txCntNxt;
  logic [BIT_W-1:0]  r_txIdx, w_txIdxNxt;
  logic [DATA_W-1:0] r_txShift, w_txShiftNxt;
  logic              r_tx, w_txLine, w_txBitDone;

  rx_state_t         r_rxState, w_rxStateNxt;
  logic [CNT_W-1:0]  r_rxCnt, w_rxCntNxt;
  logic [BIT_W-1:0]  r_rxIdx, w_rxIdxNxt;
  logic [DATA_W-1:0] r_rxShift, w_rxShiftNxt;
  logic              r_rxBreak, w_rxBreakNxt;
  logic              r_rxSync1, r_rxSync2, w_rxIn, w_rxBitDone;
  logic              w_stopSample, w_rxGood, w_parMismatch;
  logic              r_frameErr, r_overrun;
  logic              w_push, w_full, w_empty;

`ifdef UART_NIC_PARITY_EN
  logic r_txPar, r_rxPar, r_parityErr;
  assign w_parMismatch = (r_rxPar != even_parity(8'(r_rxShift)));
  assign parity_err    = r_parityErr;
`else
  assign w_parMismatch = 1'b0;
  assign parity_err    = 1'b0;
`endif

  assign tx_ready    = (r_txState == TX_IDLE);
  assign tx          = r_tx;
  assign w_txBitDone = (r_txCnt == BIT_LAST);

  // The line register follows the state by one cycle, so tx drops on the edge after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txState <= TX_IDLE;
      r_txCnt   <= '0;
      r_txIdx   <= '0;
      r_txShift <= '0;
      r_tx      <= 1'b1;
`ifdef UART_NIC_PARITY_EN
      r_txPar   <= 1'b0;
`endif
    end else begin
      r_txState <= w_txStateNxt;
      r_txCnt   <= w_txCntNxt;
      r_txIdx   <= w_txIdxNxt;
      r_txShift <= w_txShiftNxt;
      r_tx      <= w_txLine;
`ifdef UART_NIC_PARITY_EN
      if (r_txState == TX_IDLE && write_nic) r_txPar <= even_parity(8'(data_in));
`endif
    end
  end

  always_comb begin
    w_txStateNxt = r_txState;
    w_txCntNxt   = w_txBitDone ? '0 : r_txCnt + 1'b1;
    w_txIdxNxt   = r_txIdx;
    w_txShiftNxt = r_txShift;
    w_txLine     = 1'b1;
    case (r_txState)
      TX_IDLE: begin
        w_txCntNxt = '0;
        if (write_nic) begin
          w_txStateNxt = TX_START;
          w_txIdxNxt   = '0;
          w_txShiftNxt = data_in;
        end
      end
      TX_START: begin
        w_txLine = 1'b0;
        if (w_txBitDone) w_txStateNxt = TX_DATA;
      end
      TX_DATA: begin
        w_txLine = r_txShift[0];
        if (w_txBitDone) begin
          w_txShiftNxt = r_txShift >> 1;
          w_txIdxNxt   = r_txIdx + 1'b1;
          if (r_txIdx == DATA_LAST) w_txStateNxt = PAR_EN ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: begin
`ifdef UART_NIC_PARITY_EN
        w_txLine = r_txPar;
`endif
        if (w_txBitDone) w_txStateNxt = TX_STOP;
      end
      TX_STOP: begin
        if (w_txBitDone) w_txStateNxt = TX_IDLE;
      end
      default: w_txStateNxt = TX_IDLE;
    endcase
  end

  assign w_rxIn       = r_rxSync2;
  assign w_rxBitDone  = (r_rxCnt == BIT_LAST);
  assign w_stopSample = (r_rxState == RX_STOP) && !r_rxBreak && w_rxBitDone;
  assign w_rxGood     = w_stopSample && w_rxIn && !w_parMismatch;
  assign w_push       = w_rxGood && (!w_full || read_nic);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxSync1  <= 1'b1;
      r_rxSync2  <= 1'b1;
      r_rxState  <= RX_IDLE;
      r_rxCnt    <= '0;
      r_rxIdx    <= '0;
      r_rxShift  <= '0;
      r_rxBreak  <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef UART_NIC_PARITY_EN
      r_rxPar     <= 1'b0;
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_rxSync1  <= rx;
      r_rxSync2  <= r_rxSync1;
      r_rxState  <= w_rxStateNxt;
      r_rxCnt    <= w_rxCntNxt;
      r_rxIdx    <= w_rxIdxNxt;
      r_rxShift  <= w_rxShiftNxt;
      r_rxBreak  <= w_rxBreakNxt;
      r_frameErr <= w_stopSample && !w_rxIn;
      r_overrun  <= w_rxGood && w_full && !read_nic;
`ifdef UART_NIC_PARITY_EN
      if (r_rxState == RX_PARITY && w_rxBitDone) r_rxPar <= w_rxIn;
      r_parityErr <= w_stopSample && w_rxIn && w_parMismatch;
`endif
    end
  end

  // After a low stop bit the FSM parks in STOP until the line returns high.
  always_comb begin
    w_rxStateNxt = r_rxState;
    w_rxCntNxt   = w_rxBitDone ? '0 : r_rxCnt + 1'b1;
    w_rxIdxNxt   = r_rxIdx;
    w_rxShiftNxt = r_rxShift;
    w_rxBreakNxt = r_rxBreak;
    case (r_rxState)
      RX_IDLE: begin
        w_rxCntNxt = '0;
        if (!w_rxIn) w_rxStateNxt = RX_START;
      end
      RX_START: begin
        if (r_rxCnt == HALF_LAST) begin
          w_rxCntNxt   = '0;
          w_rxIdxNxt   = '0;
          w_rxStateNxt = w_rxIn ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rxBitDone) begin
          w_rxShiftNxt = {w_rxIn, r_rxShift[DATA_W-1:1]};
          w_rxIdxNxt   = r_rxIdx + 1'b1;
          if (r_rxIdx == DATA_LAST) w_rxStateNxt = PAR_EN ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (w_rxBitDone) w_rxStateNxt = RX_STOP;
      end
      RX_STOP: begin
        if (r_rxBreak) begin
          w_rxCntNxt = '0;
          if (w_rxIn) begin
            w_rxBreakNxt = 1'b0;
            w_rxStateNxt = RX_IDLE;
          end
        end else if (w_rxBitDone) begin
          if (w_rxIn) w_rxStateNxt = RX_IDLE;
          else w_rxBreakNxt = 1'b1;
        end
      end
      default: w_rxStateNxt = RX_IDLE;
    endcase
  end

  assign frame_err  = r_frameErr;
  assign overrun    = r_overrun;
  assign read_nic_i = !w_empty;

  uart_nic_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (read_nic),
    .i_data (r_rxShift),
    .o_head (data_out),
    .o_count(rx_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );

endmodule

// File: doc/uart_nic.md
# uart_nic

Parametrised UART network-interface controller: the next-generation NIC that sits between an OS-simulator front end and the serial pins, one instance per node. It serialises host writes onto `tx` and deserialises `rx` into a receive FIFO that the host drains. Data width, baud rate and FIFO depth are parameters. Framing-error and overrun reporting are included, and even parity is optional.

## Interface
- `CLK_HZ`, 50000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate; localparam `DIV = CLK_HZ/BAUD` (integer, truncated), must be ≥ 4.
- `DATA_W`, 8, data bits per frame, legal 5..8.
- `FIFO_DEPTH`, 4, RX FIFO entries, power of two ≥ 2.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `data_in`  in  DATA_W  byte to transmit.
- `write_nic`  in  1  transmit request; accepted only in the cycle `tx_ready`=1.
- `tx_ready`  out  1  transmitter idle, can accept `write_nic`.
- `tx`  out  1  serial out, idle high.
- `rx`  in  1  serial in, asynchronous to `clk`.
- `data_out`  out  DATA_W  head of RX FIFO (valid when `read_nic_i`=1).
- `read_nic`  in  1  pop RX FIFO head.
- `read_nic_i`  out  1  interrupt: RX FIFO non-empty.
- `rx_count`  out  $clog2(FIFO_DEPTH+1)  current RX FIFO occupancy.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: received byte dropped, FIFO full.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (constant 0 without `UART_NIC_PARITY_EN`).

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `read_nic_i`=0, `rx_count`=0, `data_out`=0, all error pulses 0. FIFO is emptied and both FSMs go to IDLE.
- Frame format: start (0), DATA_W data bits LSB first, optional parity, stop (1). Each bit lasts DIV cycles.
- TX FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - `write_nic` in IDLE latches `data_in` and drops `tx_ready`.
  - `write_nic` outside IDLE is ignored; there is no queueing.
- RX path: `rx` passes through a 2-flop synchroniser.
- RX FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - A falling edge in IDLE enters START. After DIV/2 cycles the line is rechecked; if high, this is a false start and the FSM returns to IDLE with no output.
  - DATA, PARITY and STOP are sampled every DIV cycles from the mid-start point.
- Stop-bit outcome:
  - Stop low: `frame_err` pulses and the byte is discarded. The FSM returns to IDLE once the line goes high.
  - Parity mismatch: `parity_err` pulses and the byte is discarded.
  - Good byte with FIFO full and no same-cycle pop: `overrun` pulses, the byte is dropped and the FIFO is unchanged.
  - Good byte with FIFO full and a same-cycle `read_nic`: both the pop and the push occur, `rx_count` is unchanged and no overrun is reported.
- `read_nic` with the FIFO empty is ignored; `rx_count` never wraps.
- `data_out` shows the FIFO head combinationally from the registered FIFO. On empty it holds its last value.
- Reset asserted mid-frame aborts both directions immediately: `tx` goes to 1 asynchronously and any partial RX byte is lost.

## Timing
- TX: `write_nic` accepted at edge N → `tx`=0 from edge N+1. Frame length is (2+DATA_W+P)·DIV cycles, where P=1 with parity and 0 without. `tx_ready` returns to 1 on the cycle after the stop bit completes.
- Back-to-back TX: a new `write_nic` in the first `tx_ready` cycle starts the next start bit on the following edge, with no extra idle bit.
- RX: push occurs at the stop-bit sample edge. `read_nic_i` and `rx_count` update on the next edge.
- Pop: `read_nic` at edge N → new head on `data_out` and decremented `rx_count` after edge N.
- Synchroniser adds 2 cycles of sampling skew; this is tolerated within the DIV/2 margin.

## Configuration
- `UART_NIC_PARITY_EN` defined: an even-parity bit is inserted after the data bits on TX and checked on RX, and `parity_err` is active.
- `UART_NIC_PARITY_EN` undefined: no parity bit on TX or RX, and `parity_err` is tied to 0.
- Both ends of a link must be built with the same setting.

## Structure
- Package `uart_pkg` holds:
  - the TX and RX state enums (IDLE, START, DATA, PARITY, STOP);
  - a function computing DIV from CLK_HZ and BAUD;
  - a function computing the parity bit.
- Sub-module `uart_nic_fifo` is a synchronous FIFO, parameterised by DATA_W and FIFO_DEPTH, with push, pop, head output and count.
- The TX FSM, RX FSM and synchroniser live in `uart_nic`.

## Test plan
Bench settings: CLK_HZ=1000000, BAUD=100000, so DIV=10; DATA_W=8, FIFO_DEPTH=4. `tx` is looped back to `rx`.
- Loopback: write 8'hA5 → `tx` shows 0,1,0,1,0,0,1,0,1,1 for 10 cycles each (100 cycles total, no parity). `read_nic_i` rises; `data_out`=8'hA5; `rx_count`=1.
- Overrun: send 5 bytes 01..05 with no reads → after the 5th frame `overrun` pulses once, `rx_count`=4, and pops return 01,02,03,04.
- Full plus simultaneous pop: FIFO full, `read_nic` asserted on the push edge of byte 8'h55 → no `overrun`, `rx_count` stays 4, and the last pop returns 8'h55.
- Framing error: drive `rx` with start, 8'hFF, and stop=0 → `frame_err` pulses and `rx_count` is unchanged.
- Glitch rejection: 3-cycle low pulse on `rx` → no push, no error pulse, RX FSM back in IDLE.
- Reset mid-frame: assert `rst_n`=0 during the 4th TX data bit → `tx`=1 and `tx_ready`=1 immediately, `rx_count`=0. After release, a new write of 8'h3C transmits and is received correctly.
